// File: rtl/mips_mem_arbiter_if.sv
// rtl/mips_mem_arbiter_if.sv - memory bus bundle (address/read/write/data/byteenable/waitrequest)
interface mips_mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   address;
    logic                read;
    logic                write;
    logic [DATA_W-1:0]   writedata;
    logic [DATA_W/8-1:0] byteenable;
    logic [DATA_W-1:0]   readdata;
    logic                waitrequest;

    modport master (
        output address, read, write, writedata, byteenable,
        input  readdata, waitrequest
    );

    modport slave (
        input  address, read, write, writedata, byteenable,
        output readdata, waitrequest
    );
endinterface

// File: rtl/mips_mem_arbiter.sv
// rtl/mips_mem_arbiter.sv - two-master round-robin arbiter onto shared RAM with stuck-slave timeout
module mips_mem_arbiter #(
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter int                TIMEOUT  = 64,
    parameter logic [DATA_W-1:0] ERR_DATA = 32'hDEADBEEF
) (
    input  logic                     clk,
    input  logic                     reset,
    mips_mem_arbiter_if.slave        m0,
    mips_mem_arbiter_if.slave        m1,
    mips_mem_arbiter_if.master       s,
    output logic [1:0]               grant,
    output logic                     timeout_err
);
    localparam int            CW       = $clog2(TIMEOUT);
    localparam logic [CW-1:0] WAIT_MAX = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

    state_t        state;
    logic          last_owner;
    logic [CW-1:0] wait_cnt;

    logic                req0, req1, owned, sel1;
    logic [ADDR_W-1:0]   a_address;
    logic                a_read, a_write, a_req, abort, a_waitrequest;
    logic [DATA_W-1:0]   a_writedata, a_readdata;
    logic [DATA_W/8-1:0] a_byteenable;

    // The owner's request is passed straight through; only the abort cycle alters it.
    always_comb begin
        req0         = m0.read | m0.write;
        req1         = m1.read | m1.write;
        owned        = (state != IDLE);
        sel1         = (state == OWN1);
        a_address    = sel1 ? m1.address    : m0.address;
        a_read       = sel1 ? m1.read       : m0.read;
        a_write      = sel1 ? m1.write      : m0.write;
        a_writedata  = sel1 ? m1.writedata  : m0.writedata;
        a_byteenable = sel1 ? m1.byteenable : m0.byteenable;
        a_req        = a_read | a_write;
        abort        = owned && a_req && s.waitrequest && (wait_cnt == WAIT_MAX);

        s.address    = owned ? a_address    : '0;
        s.writedata  = owned ? a_writedata  : '0;
        s.byteenable = owned ? a_byteenable : '0;
        s.read       = owned && a_read && !a_write && !abort;
        s.write      = owned && a_write && !abort;

        a_waitrequest = s.waitrequest && !abort;
        a_readdata    = (abort && !a_write) ? ERR_DATA : s.readdata;

        m0.waitrequest = (state == OWN0) ? a_waitrequest : 1'b1;
        m0.readdata    = (state == OWN0) ? a_readdata    : '0;
        m1.waitrequest = (state == OWN1) ? a_waitrequest : 1'b1;
        m1.readdata    = (state == OWN1) ? a_readdata    : '0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            last_owner  <= 1'b1;
            wait_cnt    <= '0;
            grant       <= 2'b00;
            timeout_err <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    wait_cnt <= '0;
                    if (req0 && (!req1 || last_owner)) begin
                        state <= OWN0;
                        grant <= 2'b01;
                    end else if (req1) begin
                        state <= OWN1;
                        grant <= 2'b10;
                    end
                end
                default: begin
                    if (!a_req) begin
                        // Master withdrew mid-transfer: release without updating fairness.
                        state    <= IDLE;
                        grant    <= 2'b00;
                        wait_cnt <= '0;
                    end else if (!s.waitrequest || abort) begin
                        state      <= IDLE;
                        grant      <= 2'b00;
                        last_owner <= sel1;
                        wait_cnt   <= '0;
                        if (abort) begin
                            timeout_err <= 1'b1;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mips_mem_arbiter.sv
// tb/tb_mips_mem_arbiter.sv - randomized scoreboard bench for mips_mem_arbiter
module tb_mips_mem_arbiter;
    localparam int          TMO = 4;
    localparam logic [31:0] ERR = 32'hDEADBEEF;

    typedef struct { bit is_read; bit tmo; logic [31:0] rdata; int waits; } mexp_t;
    typedef struct { logic [31:0] addr; bit wr; logic [31:0] wdata; logic [3:0] be; } sexp_t;

    mexp_t mq0[$], mq1[$];
    sexp_t sq0[$], sq1[$];

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        m_rd[2], m_wr[2];
    logic [31:0] m_addr[2], m_wd[2];
    logic [3:0]  m_be[2];
    logic [31:0] m_rdata[2];
    logic        m_wait[2];
    logic [1:0]  grant;
    logic        timeout_err;

    int tests = 0, fails = 0;
    bit mon_en = 1'b0, err_exp = 1'b0;
    int wcyc[2], stall[2], scnt;
    logic [31:0] smem [0:127];
    logic [31:0] ref_mem [0:127];

    mips_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) m0_bus();
    mips_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) m1_bus();
    mips_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) s_bus();

    assign m0_bus.address = m_addr[0];  assign m1_bus.address = m_addr[1];
    assign m0_bus.read = m_rd[0];       assign m1_bus.read = m_rd[1];
    assign m0_bus.write = m_wr[0];      assign m1_bus.write = m_wr[1];
    assign m0_bus.writedata = m_wd[0];  assign m1_bus.writedata = m_wd[1];
    assign m0_bus.byteenable = m_be[0]; assign m1_bus.byteenable = m_be[1];
    assign m_rdata[0] = m0_bus.readdata;   assign m_rdata[1] = m1_bus.readdata;
    assign m_wait[0] = m0_bus.waitrequest; assign m_wait[1] = m1_bus.waitrequest;

    // Slave RAM: stall length is chosen by whichever master currently holds the grant.
    assign s_bus.readdata    = smem[s_bus.address[8:2]];
    assign s_bus.waitrequest = (scnt < ((grant == 2'b10) ? stall[1] : stall[0]));

    always @(posedge clk) begin
        scnt <= (grant == 2'b00) ? 0 : scnt + 1;
        if (s_bus.write && !s_bus.waitrequest) begin
            for (int b = 0; b < 4; b++) begin
                if (s_bus.byteenable[b]) smem[s_bus.address[8:2]][8*b +: 8] <= s_bus.writedata[8*b +: 8];
            end
        end
    end

    mips_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TMO), .ERR_DATA(ERR)) dut (
        .clk(clk), .reset(reset), .m0(m0_bus), .m1(m1_bus), .s(s_bus),
        .grant(grant), .timeout_err(timeout_err)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: pops expected responses whenever a master or the slave completes a beat.
    always @(negedge clk) begin
        mexp_t e;
        sexp_t se;
        bit got;
        if (mon_en) begin
            for (int i = 0; i < 2; i++) begin
                if ((m_rd[i] || m_wr[i]) && !m_wait[i]) begin
                    got = 1'b0;
                    if (i == 0 && mq0.size() > 0) begin e = mq0.pop_front(); got = 1'b1; end
                    if (i == 1 && mq1.size() > 0) begin e = mq1.pop_front(); got = 1'b1; end
                    check($sformatf("m%0d_unexpected_done", i), 32'(got), 32'd1);
                    if (got) begin
                        check($sformatf("m%0d_grant", i), 32'(grant), 32'(1 << i));
                        check($sformatf("m%0d_wait_cycles", i), wcyc[i], e.waits);
                        if (e.is_read) check($sformatf("m%0d_rdata", i), m_rdata[i], e.rdata);
                        check("timeout_err", 32'(timeout_err), 32'(err_exp));
                        if (e.tmo) err_exp = 1'b1;
                    end
                    wcyc[i] = 0;
                end else if (grant == 2'(1 << i) && m_wait[i]) begin
                    wcyc[i]++;
                end
            end
            if ((s_bus.read || s_bus.write) && !s_bus.waitrequest) begin
                check("s_rw_exclusive", 32'(s_bus.read && s_bus.write), 32'd0);
                got = 1'b0;
                if (grant == 2'b01 && sq0.size() > 0) begin se = sq0.pop_front(); got = 1'b1; end
                if (grant == 2'b10 && sq1.size() > 0) begin se = sq1.pop_front(); got = 1'b1; end
                check("s_unexpected_beat", 32'(got), 32'd1);
                if (got) begin
                    check("s_address", s_bus.address, se.addr);
                    check("s_write", 32'(s_bus.write), 32'(se.wr));
                    check("s_byteenable", 32'(s_bus.byteenable), 32'(se.be));
                    if (se.wr) check("s_writedata", s_bus.writedata, se.wdata);
                end
            end
        end
    end

    task automatic drive(input int i, input int n);
        for (int k = 0; k < n; k++) begin
            int word, op, st, cyc, gap;
            logic [31:0] wd;
            logic [3:0] be;
            mexp_t e;
            sexp_t se;
            gap = $urandom_range(0, 3);
            if (gap > 0) begin
                repeat (gap) @(posedge clk);
                #1;
            end
            word = i * 64 + $urandom_range(0, 63);
            op   = $urandom_range(0, 2);   // 0 read, 1 write, 2 read+write (write wins)
            st   = $urandom_range(0, 5);
            if (st == 5) st = 50;
            wd   = $urandom;
            be   = 4'($urandom);
            e.is_read = (op == 0);
            e.tmo     = (st >= TMO);
            e.waits   = e.tmo ? TMO - 1 : st;
            e.rdata   = e.tmo ? ERR : ref_mem[word];
            if (!e.tmo) begin
                if (op != 0) begin
                    for (int b = 0; b < 4; b++) if (be[b]) ref_mem[word][8*b +: 8] = wd[8*b +: 8];
                end
                se.addr = 32'(word) << 2; se.wr = (op != 0); se.wdata = wd; se.be = be;
                if (i == 0) sq0.push_back(se); else sq1.push_back(se);
            end
            if (i == 0) mq0.push_back(e); else mq1.push_back(e);
            stall[i] = st; m_addr[i] = 32'(word) << 2; m_wd[i] = wd; m_be[i] = be;
            m_rd[i] = (op != 1); m_wr[i] = (op != 0);
            cyc = 0;
            do begin
                @(negedge clk);
                cyc++;
            end while (m_wait[i] && cyc < 400);
            if (m_wait[i]) begin
                tests++; fails++;
                $display("FAIL m%0d_completion: got no completion after %0d cycles, expected completion", i, cyc);
            end
            @(posedge clk); #1;
            m_rd[i] = 1'b0; m_wr[i] = 1'b0;
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            m_rd[i] = 0; m_wr[i] = 0; m_addr[i] = 0; m_wd[i] = 0; m_be[i] = 0; stall[i] = 0;
        end
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
    endtask

    logic [1:0] gseq [6];

    initial begin
        for (int w = 0; w < 128; w++) smem[w] = 32'h5A5A0000 ^ (32'(w) * 32'h01010101);
        smem[4] = 32'h1234ABCD;
        for (int i = 0; i < 2; i++) begin
            m_rd[i] = 0; m_wr[i] = 0; m_addr[i] = 0; m_wd[i] = 0; m_be[i] = 0; stall[i] = 0; wcyc[i] = 0;
        end
        #12;
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_s_read", 32'(s_bus.read), 32'd0);
        check("rst_s_write", 32'(s_bus.write), 32'd0);
        check("rst_s_address", s_bus.address, 32'd0);
        check("rst_m0_wait", 32'(m_wait[0]), 32'd1);
        check("rst_m1_wait", 32'(m_wait[1]), 32'd1);
        check("rst_m0_rdata", m_rdata[0], 32'd0);
        check("rst_timeout_err", 32'(timeout_err), 32'd0);
        @(posedge clk); #1 reset = 1'b1;

        // Single read: one arbitration cycle, then the slave sees the read.
        m_rd[0] = 1'b1; m_addr[0] = 32'h10;
        @(negedge clk);
        check("rd_arb_grant", 32'(grant), 32'd0);
        check("rd_arb_s_read", 32'(s_bus.read), 32'd0);
        @(negedge clk);
        check("rd_s_read", 32'(s_bus.read), 32'd1);
        check("rd_s_address", s_bus.address, 32'h10);
        check("rd_m0_wait", 32'(m_wait[0]), 32'd0);
        check("rd_m0_rdata", m_rdata[0], 32'h1234ABCD);
        check("rd_grant", 32'(grant), 32'd1);
        @(posedge clk); #1 m_rd[0] = 1'b0;
        @(negedge clk);
        check("rd_idle_grant", 32'(grant), 32'd0);

        // Contention from reset: round-robin alternation with an idle cycle between owners.
        do_reset();
        gseq = '{2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01};
        m_rd[0] = 1'b1; m_addr[0] = 32'h20;
        m_wr[1] = 1'b1; m_addr[1] = 32'h120; m_wd[1] = 32'hCAFEF00D; m_be[1] = 4'b0011;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check($sformatf("cont_grant_%0d", k), 32'(grant), 32'(gseq[k]));
            if (k == 3) begin
                check("cont_s_write", 32'(s_bus.write), 32'd1);
                check("cont_s_wdata", s_bus.writedata, 32'hCAFEF00D);
                check("cont_s_be", 32'(s_bus.byteenable), 32'b0011);
                check("cont_s_addr", s_bus.address, 32'h120);
            end
            @(posedge clk); #1;
            if (k == 3) m_wr[1] = 1'b0;
        end
        m_rd[0] = 1'b0;

        // Read and write together: the write is forwarded, the read is not.
        do_reset();
        m_rd[0] = 1'b1; m_wr[0] = 1'b1; m_addr[0] = 32'h30; m_wd[0] = 32'h0BADF00D; m_be[0] = 4'hF;
        @(negedge clk); @(negedge clk);
        check("rw_s_write", 32'(s_bus.write), 32'd1);
        check("rw_s_read", 32'(s_bus.read), 32'd0);
        @(posedge clk); #1 m_rd[0] = 1'b0; m_wr[0] = 1'b0;

        // Reset during a stalled m1 read drops everything without a clock edge.
        do_reset();
        stall[1] = 99; m_rd[1] = 1'b1; m_addr[1] = 32'h140;
        @(negedge clk); @(negedge clk);
        check("rmw_grant_before", 32'(grant), 32'd2);
        #1 reset = 1'b0;
        #1;
        check("rmw_grant", 32'(grant), 32'd0);
        check("rmw_s_read", 32'(s_bus.read), 32'd0);
        check("rmw_m0_wait", 32'(m_wait[0]), 32'd1);
        check("rmw_m1_wait", 32'(m_wait[1]), 32'd1);
        stall[1] = 0; m_rd[0] = 1'b1; m_addr[0] = 32'h40;
        @(posedge clk); #1 reset = 1'b1;
        @(negedge clk); @(negedge clk);
        check("rmw_first_grant", 32'(grant), 32'd1);
        @(posedge clk); #1 m_rd[0] = 1'b0; m_rd[1] = 1'b0;

        // Randomized phase: both masters in parallel, including wait states and timeouts.
        do_reset();
        for (int w = 0; w < 128; w++) ref_mem[w] = smem[w];
        wcyc[0] = 0; wcyc[1] = 0; err_exp = 1'b0; mon_en = 1'b1;
        fork
            drive(0, 60);
            drive(1, 60);
        join
        repeat (4) @(negedge clk);
        mon_en = 1'b0;
        check("m0_queue_empty", mq0.size(), 0);
        check("m1_queue_empty", mq1.size(), 0);
        check("s0_queue_empty", sq0.size(), 0);
        check("s1_queue_empty", sq1.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/mips_mem_arbiter.md
Name: mips_mem_arbiter

Overview:
- Two-master to one-slave arbiter for the CPU memory bus (address/read/write/writedata/byteenable/readdata/waitrequest).
- Master 0 is the mips_cpu_bus data/instruction port. Master 1 is a loader/debug port that fills or inspects RAM while the CPU runs.
- The slave is the shared RAM.
- Provides round-robin arbitration, a grant held for a whole transaction, and a stuck-slave timeout.

Parameters:
- ADDR_W, 32, address width for all ports.
- DATA_W, 32, data width; byteenable width is DATA_W/8.
- TIMEOUT, 64, maximum consecutive waitrequest cycles before abort (>=2).
- ERR_DATA, 32'hDEADBEEF, readdata returned on an aborted read.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-low reset; logic is in reset while reset==0.
- m0_address/m1_address  in  ADDR_W  master byte address.
- m0_read/m1_read  in  1  read request.
- m0_write/m1_write  in  1  write request.
- m0_writedata/m1_writedata  in  DATA_W  write data.
- m0_byteenable/m1_byteenable  in  DATA_W/8  byte lanes.
- m0_readdata/m1_readdata  out  DATA_W  read data.
- m0_waitrequest/m1_waitrequest  out  1  stall to master.
- s_address  out  ADDR_W  to slave.
- s_read, s_write  out  1  to slave.
- s_writedata  out  DATA_W  to slave.
- s_byteenable  out  DATA_W/8  to slave.
- s_readdata  in  DATA_W  from slave.
- s_waitrequest  in  1  from slave.
- grant  out  2  one-hot owner; 2'b00 when idle.
- timeout_err  out  1  sticky abort flag.

Behaviour:
- Definitions: req_x = mx_read | mx_write. If a master asserts read and write together, the write wins and the read is not forwarded.
- FSM states: IDLE, OWN0, OWN1. A registered last_owner bit holds the previous owner.
- Reset (reset==0, async):
  - state=IDLE, last_owner=1 so master 0 wins the first tie.
  - wait counter = 0; timeout_err=0.
  - grant=0; s_read=s_write=0; s_address/s_writedata/s_byteenable=0.
  - m0/m1_waitrequest=1; m0/m1_readdata=0.
- IDLE:
  - Slave read/write held 0; both master waitrequests = 1.
  - Only req_0 -> OWN0. Only req_1 -> OWN1.
  - Both requesting -> own the master that is not last_owner.
  - Arbitration costs exactly one cycle; a request raised in cycle N reaches the slave in cycle N+1.
- OWNx:
  - grant=one-hot x.
  - Slave address/writedata/byteenable/read/write driven combinationally from master x.
  - mx_waitrequest = s_waitrequest; mx_readdata = s_readdata.
  - The other master sees waitrequest=1 and readdata=0.
- Completion: in OWNx, with req_x and s_waitrequest==0, the transfer completes that cycle. Next state is IDLE, last_owner<=x, wait counter<=0. Back-to-back transfers from one master therefore take at least 2 cycles each (no bus parking).
- Withdrawal: in OWNx with req_x==0 (master protocol violation) -> IDLE next cycle; last_owner is unchanged.
- Timeout:
  - The wait counter increments each OWNx cycle with s_waitrequest==1 and resets otherwise.
  - When the counter reaches TIMEOUT-1 while s_waitrequest is still 1, that cycle:
    - mx_waitrequest is forced to 0.
    - mx_readdata=ERR_DATA on a read.
    - s_read/s_write are forced to 0.
  - Next state IDLE, last_owner<=x, timeout_err<=1.
  - timeout_err stays set until reset.
- Requests arriving while the other master owns the bus wait; they are served next by round-robin. Starvation is bounded to one transaction.
- Reset asserted mid-transaction immediately returns all outputs to reset values. The slave sees read/write drop asynchronously.

Test Plan:
- Single read: m0_read=1, m0_address=0x10, slave returns 0x1234ABCD with waitrequest 0. Required: s_read high in cycle 2, m0_waitrequest low and m0_readdata=0x1234ABCD in the same cycle, grant=01, then IDLE.
- Contention: m0 and m1 both request from reset. Required grant sequence 01, 00, 10, 00, 01; m1's write of 0xCAFEF00D with byteenable 4'b0011 reaches the slave intact.
- Wait states: slave holds waitrequest for 3 cycles on an m1 read. Required: m1_waitrequest high 3 cycles; m0 requests meanwhile and is granted only after m1 completes; no timeout_err.
- Timeout (TIMEOUT=4): slave waitrequest stuck at 1. Required: on the 4th owned cycle m0_waitrequest=0 and m0_readdata=0xDEADBEEF; timeout_err=1 and stays 1; bus serves m1 afterwards.
- Read+write together: m0_read=m0_write=1. Required: s_write=1, s_read=0.
- Reset mid-wait: drop reset during OWN1 with waitrequest high. Required: grant=00, s_read=0, both waitrequest=1 without a clock edge; first request after release goes to m0.
